// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin arbiter sharing one slave port among several masters
// Read responses are steered back through an in-order FIFO of granted master IDs.
module bus_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int RESP_DEPTH  = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_MASTERS-1:0]          m_req_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_bi,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_bi,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_resp_o,
  output logic [DATA_W-1:0]               m_rdata_bo,
  output logic                            s_req_o,
  output logic                            s_we_o,
  output logic [ADDR_W-1:0]               s_addr_bo,
  output logic [DATA_W/8-1:0]             s_be_o,
  output logic [DATA_W-1:0]               s_wdata_bo,
  input  logic                            s_ack_i,
  input  logic                            s_resp_i,
  input  logic [DATA_W-1:0]               s_rdata_bi,
  output logic [$clog2(RESP_DEPTH):0]     outstanding_o,
  output logic                            resp_err_o
);

  localparam int ID_W  = $clog2(NUM_MASTERS);
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BE_W  = DATA_W / 8;

  logic [ADDR_W-1:0] addr_arr  [NUM_MASTERS];
  logic [BE_W-1:0]   be_arr    [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign addr_arr[k]  = m_addr_bi[k*ADDR_W +: ADDR_W];
    assign be_arr[k]    = m_be_i[k*BE_W +: BE_W];
    assign wdata_arr[k] = m_wdata_bi[k*DATA_W +: DATA_W];
  end

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant;
  logic [ID_W:0]    cand;
  logic             any_req;
  logic [ID_W-1:0]  id_mem [RESP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             err_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             blocked;
  logic             handshake;
  logic             push;
  logic             pop;

  // Search starts at rr_ptr and wraps; the first requester found wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_MASTERS)) cand = cand - (ID_W+1)'(NUM_MASTERS);
      if (!any_req && m_req_i[cand[ID_W-1:0]]) begin
        any_req = 1'b1;
        grant   = cand[ID_W-1:0];
      end
    end
  end

  assign fifo_full  = (count == CNT_W'(RESP_DEPTH));
  assign fifo_empty = (count == '0);

  // A read at full stalls the granted master rather than skipping it, keeping order fair.
  assign blocked    = any_req && !m_we_i[grant] && fifo_full;
  assign s_req_o    = any_req && !blocked && !rst_i;
  assign s_we_o     = any_req ? m_we_i[grant]    : 1'b0;
  assign s_addr_bo  = any_req ? addr_arr[grant]  : '0;
  assign s_be_o     = any_req ? be_arr[grant]    : '0;
  assign s_wdata_bo = any_req ? wdata_arr[grant] : '0;

  assign handshake  = s_req_o && s_ack_i;
  assign push       = handshake && !s_we_o;
  assign pop        = s_resp_i && !fifo_empty && !rst_i;

  assign m_ack_o       = handshake ? (NUM_MASTERS'(1) << grant) : '0;
  assign m_resp_o      = pop ? (NUM_MASTERS'(1) << id_mem[rd_ptr]) : '0;
  assign m_rdata_bo    = s_rdata_bi;
  assign outstanding_o = count;
  assign resp_err_o    = err_q;

  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (handshake) rr_ptr <= (grant == ID_W'(NUM_MASTERS-1)) ? '0 : grant + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (s_resp_i && fifo_empty) err_q <= 1'b1;
    end
  end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Shares one MemSplit32-style slave port among NUM_MASTERS requesters on the req/we/addr/be/wdata/ack/resp/rdata bus.
- Placed in front of a shared peripheral, such as the gpio port behind the xbar, when several tiles or the udm need it without a full crossbar.
- Grants in round-robin order and records the master ID of every accepted read in an in-order FIFO. Read responses are steered back to the master that issued the read.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8).
- RESP_DEPTH, 4, max outstanding reads; power of 2, at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; be width is DATA_W/8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- m_req_i  in  NUM_MASTERS  per-master request.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_addr_bi  in  NUM_MASTERS*ADDR_W  flattened addresses; master k at bits [k*ADDR_W +: ADDR_W].
- m_be_i  in  NUM_MASTERS*DATA_W/8  flattened byte enables.
- m_wdata_bi  in  NUM_MASTERS*DATA_W  flattened write data.
- m_ack_o  out  NUM_MASTERS  per-master accept.
- m_resp_o  out  NUM_MASTERS  per-master read-data valid.
- m_rdata_bo  out  DATA_W  read data, broadcast to all masters; qualified by m_resp_o.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_bo  out  ADDR_W  slave address.
- s_be_o  out  DATA_W/8  slave byte enables.
- s_wdata_bo  out  DATA_W  slave write data.
- s_ack_i  in  1  slave accept.
- s_resp_i  in  1  slave read-data valid.
- s_rdata_bi  in  DATA_W  slave read data.
- outstanding_o  out  $clog2(RESP_DEPTH)+1  count of reads accepted but not yet responded.
- resp_err_o  out  1  sticky flag: s_resp_i arrived with no outstanding read.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - rr_ptr=0, FIFO empty, outstanding_o=0, resp_err_o=0.
  - While rst_i=1: s_req_o=0, all m_ack_o=0, all m_resp_o=0.
  - Any in-flight read is dropped.
- Grant selection (combinational):
  - g = first master with m_req_i=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
  - s_we_o/s_addr_bo/s_be_o/s_wdata_bo mux from master g.
  - When no master requests, all mux outputs are 0.
- Read blocking:
  - If master g presents a read (m_we_i[g]=0) and the FIFO is full, s_req_o=0.
  - The arbiter does not skip to another master. It holds until a response frees a slot.
  - Writes are never blocked.
- Request and accept:
  - s_req_o = any m_req_i and not blocked.
  - m_ack_o[g] = s_req_o & s_ack_i. All other m_ack_o are 0.
  - Zero added latency on the request path.
- Handshake (s_req_o & s_ack_i at a clock edge):
  - rr_ptr <= (g+1) mod NUM_MASTERS.
  - If the handshake is a read, push g into the FIFO.
  - Without a handshake, rr_ptr holds, so a pending master keeps the grant across slave stalls.
- Response:
  - When s_resp_i=1 and the FIFO is non-empty: m_resp_o[head]=1 combinationally, m_rdata_bo=s_rdata_bi, pop at the edge.
  - Response latency through the arbiter is 0 cycles.
  - Responses return in issue order; the slave is in-order.
- Simultaneous push and pop in one cycle:
  - Both happen; the count is unchanged.
  - A push is never attempted at full, since reads are blocked there.
  - A pop at full, together with a read accepted the same cycle, is not possible, because the read was blocked combinationally that cycle.
- Unexpected response:
  - s_resp_i=1 with the FIFO empty: no m_resp_o asserted, resp_err_o<=1.
  - resp_err_o is cleared only by reset.
- FIFO:
  - Circular buffer with wr/rd pointers that wrap modulo RESP_DEPTH.
  - Count in outstanding_o, range 0..RESP_DEPTH.
- The slave must not assert s_resp_i for a read in the same cycle as that read's s_ack_i.

Test Plan:
- Fairness: masters 0,1,2,3 hold reads, slave acks every cycle → grants 0,1,2,3,0,1; the four responses (0x11,0x22,0x33,0x44, one cycle after each ack) reach m_resp_o bits 0,1,2,3 respectively with matching rdata.
- Slave stall: master 2 writes addr 0x8000_0004 with s_ack_i=0 for 3 cycles while master 3 also requests → s_addr_bo stays 0x8000_0004, m_ack_o=0b0100 only on the 4th cycle; rr_ptr becomes 3.
- FIFO full (RESP_DEPTH=4): 4 reads accepted, no responses → outstanding_o=4; a 5th read gives s_req_o=0; a master-1 write that is the next RR choice still passes; one s_resp_i → the read proceeds next cycle.
- Push and pop together: with outstanding_o=2, accept a read and receive a response in the same cycle → outstanding_o stays 2; the response is routed to the oldest ID.
- Error path: s_resp_i=1 with the FIFO empty → all m_resp_o=0 and resp_err_o=1, persisting until rst_i.
- Reset mid-operation: assert rst_i with 3 outstanding reads → next cycle outstanding_o=0, s_req_o=0, rr_ptr=0; first post-reset request from master 0 is granted.
